multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle main controller for the RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback states. It drives the datapath control signals (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch) plus PC/IR write enables, and waits on a memory ready handshake with a bounded timeout. It sits between the instruction register and the shared datapath. It replaces single-cycle opcode decode whenever the core runs in multi-cycle mode.

## Interface
- TIMEOUT, 16, max wait cycles in any memory state before abort; legal range 2..255
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- Opcode  in  7  instr[6:0] from IR; valid and sampled only in DECODE
- mem_ready  in  1  memory handshake: current fetch/read/write completes this cycle
- PCWrite  out  1  PC <= PC+4 this cycle
- IRWrite  out  1  IR <= fetched word this cycle
- ALUSrc  out  1  0: rs2; 1: immediate
- MemtoReg  out  1  0: ALU result; 1: memory data to rd
- RegWrite  out  1  write rd
- MemRead  out  1  data-memory read request
- MemWrite  out  1  data-memory write request
- ALUOp  out  2  00: LW/SW address; 01: branch compare; 10: R/I-type
- Branch  out  1  branch evaluation cycle; the external PC logic takes the branch when Branch&Zero
- ifetch_req  out  1  instruction-memory read request
- instr_done  out  1  one-cycle pulse when an instruction retires
- mem_err  out  1  one-cycle pulse on memory timeout
- illegal  out  1  level, illegal opcode trapped (ILLEGAL_TRAP_EN only, else tied 0)

## Operation
- Opcodes: R_TYPE 0110011, I_TYPE 0010011, LW 0000011, SW 0100011, BR 1100011.
- Outputs not listed for a state are 0. Outputs are Moore decodes of the state, except the terms qualified by mem_ready.
- IDLE: all 0. Next state FETCH.
- FETCH: ifetch_req=1. If mem_ready: IRWrite=1, PCWrite=1, next DECODE. Otherwise stay.
- DECODE: all 0. Next state by Opcode:
  - R_TYPE/I_TYPE -> EXEC
  - LW/SW -> MEM_ADDR
  - BR -> BRANCH
  - other -> see Configuration
- EXEC: ALUOp=10, ALUSrc=(Opcode==I_TYPE). Next WB_ALU.
- WB_ALU: ALUOp=10, ALUSrc as in EXEC, RegWrite=1, instr_done=1. Next FETCH.
- MEM_ADDR: ALUSrc=1, ALUOp=00. Next MEM_RD if LW, MEM_WR if SW.
- MEM_RD: ALUSrc=1, ALUOp=00, MemRead=1. On mem_ready, next WB_MEM.
- WB_MEM: MemtoReg=1, RegWrite=1, instr_done=1. Next FETCH.
- MEM_WR: ALUSrc=1, ALUOp=00, MemWrite=1. On mem_ready: instr_done=1, next FETCH.
- BRANCH: ALUOp=01, Branch=1, instr_done=1. Next FETCH.
- Opcode is re-read in EXEC and MEM_ADDR; the IR is stable because IRWrite only fires in FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR; increments each cycle in those states without mem_ready.
  - Width is $clog2(TIMEOUT+1).
  - When the counter equals TIMEOUT-1 and mem_ready=0: mem_err=1, next FETCH. No IRWrite/PCWrite/RegWrite occurs; the instruction is abandoned and instr_done stays 0.
  - If mem_ready=1 in the timeout cycle, completion wins and mem_err stays 0.

## Timing
- Reset: all outputs 0 and the counter cleared immediately (async). The first FETCH is the cycle after reset deasserts.
- Latency with mem_ready tied 1, FETCH to retire inclusive:
  - R/I-type: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BR: 3 cycles
- Each cycle of memory wait adds exactly 1 cycle.
- MemRead/MemWrite/ifetch_req stay high continuously from state entry until the completing or aborting cycle. They drop the cycle after.
- Reset asserted mid-MEM_WR: MemWrite falls asynchronously. The write is not retried.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - Unknown opcode in DECODE goes to TRAP.
  - TRAP holds illegal=1 with all other outputs 0.
  - Only reset exits TRAP.
- Not defined:
  - Unknown opcode is a NOP: DECODE pulses instr_done=1 and goes to FETCH.
  - illegal is tied to 0.

## Test plan
- addi (0010011), mem_ready=1: IRWrite/PCWrite at cycle 1, ALUSrc=1 and ALUOp=10 at cycle 3, RegWrite and instr_done at cycle 4, next FETCH.
- lw with mem_ready low for 3 cycles in MEM_RD: MemRead high for 4 cycles, then WB_MEM with MemtoReg=1 and RegWrite=1; total 8 cycles.
- beq: BRANCH state drives Branch=1, ALUOp=01, ALUSrc=0, and instr_done in the same cycle; RegWrite and MemWrite never assert.
- sw with mem_ready held 0, TIMEOUT=4: MemWrite high for 4 cycles, mem_err pulses in the 4th, no instr_done, FETCH follows. Repeat with mem_ready=1 in the 4th cycle: instr_done=1 and mem_err=0.
- Opcode 1111111: with ILLEGAL_TRAP_EN, illegal=1 stays high for 20 cycles and clears on reset. Without the macro, instr_done pulses in DECODE and the next cycle is FETCH.
- Reset asserted in MEM_WR mid-wait: MemWrite=0 in the same cycle; after deassert, IDLE for 1 cycle, then ifetch_req=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I main controller (fetch/decode/exec/mem/wb)
// Optional: ILLEGAL_TRAP_EN traps unknown opcodes in TRAP instead of retiring them as NOPs.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] ALUOp,
  output logic       Branch,
  output logic       ifetch_req,
  output logic       instr_done,
  output logic       mem_err,
  output logic       illegal
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB_ALU,
    MEM_ADDR,
    MEM_RD,
    WB_MEM,
    MEM_WR,
    BRANCH
`ifdef ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timed_out;

  assign timed_out = (cnt_q == LAST) && !mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter is zero outside the wait states, so entering one always starts from 0.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ALUOp      = 2'b00;
    Branch     = 1'b0;
    ifetch_req = 1'b0;
    instr_done = 1'b0;
    mem_err    = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        ifetch_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end else if (timed_out) begin
          mem_err = 1'b1;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DECODE: begin
        case (Opcode)
          OP_R, OP_I:   state_d = EXEC;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BR:        state_d = BRANCH;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = TRAP;
`else
            instr_done = 1'b1;
            state_d    = FETCH;
`endif
          end
        endcase
      end
      EXEC: begin
        ALUOp   = 2'b10;
        ALUSrc  = (Opcode == OP_I);
        state_d = WB_ALU;
      end
      WB_ALU: begin
        ALUOp      = 2'b10;
        ALUSrc     = (Opcode == OP_I);
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_ADDR: begin
        ALUSrc  = 1'b1;
        state_d = (Opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        ALUSrc  = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) begin
          state_d = WB_MEM;
        end else if (timed_out) begin
          mem_err = 1'b1;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WB_MEM: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        ALUSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end else if (timed_out) begin
          mem_err = 1'b1;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BRANCH: begin
        ALUOp      = 2'b01;
        Branch     = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: illegal = 1'b1;
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule
